// File: rtl/keyboard_ascii_fifo_pkg.sv
// Shared scan-code / ASCII constants and the pipeline bundle for the
// keyboard-to-ASCII consumer stage.
package keyboard_ascii_fifo_pkg;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;

  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_TAB    = 8'h0D;
  localparam logic [7:0] SC_ESC    = 8'h76;

  localparam logic [7:0] ASC_NUL   = 8'h00;
  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_BS    = 8'h08;
  localparam logic [7:0] ASC_TAB   = 8'h09;
  localparam logic [7:0] ASC_ESC   = 8'h1B;

  typedef struct packed {
    logic       push;
    logic [7:0] ch;
  } kb_pipe_t;

  function automatic logic is_modifier(input logic [7:0] c);
    return (c == SC_LSHIFT) || (c == SC_RSHIFT) || (c == SC_CAPS);
  endfunction

endpackage

// File: rtl/keyboard_ascii_fifo_rom.sv
// Scan set 2 (US layout) make code to ASCII; 8'h00 means unmapped.
module ps2_ascii_rom
  import keyboard_ascii_fifo_pkg::*;
(
  input  logic [7:0] i_code,
  input  logic       i_shift,
  input  logic       i_caps,
  output logic [7:0] o_ascii
);

  logic [7:0] w_lo;
  logic [7:0] w_hi;
  logic       w_alpha;

  always_comb begin
    w_lo    = ASC_NUL;
    w_hi    = ASC_NUL;
    w_alpha = 1'b0;
    case (i_code)
      8'h1C: {w_alpha, w_lo} = {1'b1, "a"};
      8'h32: {w_alpha, w_lo} = {1'b1, "b"};
      8'h21: {w_alpha, w_lo} = {1'b1, "c"};
      8'h23: {w_alpha, w_lo} = {1'b1, "d"};
      8'h24: {w_alpha, w_lo} = {1'b1, "e"};
      8'h2B: {w_alpha, w_lo} = {1'b1, "f"};
      8'h34: {w_alpha, w_lo} = {1'b1, "g"};
      8'h33: {w_alpha, w_lo} = {1'b1, "h"};
      8'h43: {w_alpha, w_lo} = {1'b1, "i"};
      8'h3B: {w_alpha, w_lo} = {1'b1, "j"};
      8'h42: {w_alpha, w_lo} = {1'b1, "k"};
      8'h4B: {w_alpha, w_lo} = {1'b1, "l"};
      8'h3A: {w_alpha, w_lo} = {1'b1, "m"};
      8'h31: {w_alpha, w_lo} = {1'b1, "n"};
      8'h44: {w_alpha, w_lo} = {1'b1, "o"};
      8'h4D: {w_alpha, w_lo} = {1'b1, "p"};
      8'h15: {w_alpha, w_lo} = {1'b1, "q"};
      8'h2D: {w_alpha, w_lo} = {1'b1, "r"};
      8'h1B: {w_alpha, w_lo} = {1'b1, "s"};
      8'h2C: {w_alpha, w_lo} = {1'b1, "t"};
      8'h3C: {w_alpha, w_lo} = {1'b1, "u"};
      8'h2A: {w_alpha, w_lo} = {1'b1, "v"};
      8'h1D: {w_alpha, w_lo} = {1'b1, "w"};
      8'h22: {w_alpha, w_lo} = {1'b1, "x"};
      8'h35: {w_alpha, w_lo} = {1'b1, "y"};
      8'h1A: {w_alpha, w_lo} = {1'b1, "z"};
      8'h16: {w_lo, w_hi} = {"1", "!"};
      8'h1E: {w_lo, w_hi} = {"2", "@"};
      8'h26: {w_lo, w_hi} = {"3", "#"};
      8'h25: {w_lo, w_hi} = {"4", "$"};
      8'h2E: {w_lo, w_hi} = {"5", "%"};
      8'h36: {w_lo, w_hi} = {"6", "^"};
      8'h3D: {w_lo, w_hi} = {"7", "&"};
      8'h3E: {w_lo, w_hi} = {"8", "*"};
      8'h46: {w_lo, w_hi} = {"9", "("};
      8'h45: {w_lo, w_hi} = {"0", ")"};
      8'h4E: {w_lo, w_hi} = {"-", "_"};
      8'h55: {w_lo, w_hi} = {"=", "+"};
      8'h41: {w_lo, w_hi} = {",", "<"};
      8'h49: {w_lo, w_hi} = {".", ">"};
      8'h4A: {w_lo, w_hi} = {"/", "?"};
      8'h4C: {w_lo, w_hi} = {";", ":"};
      8'h52: {w_lo, w_hi} = {8'h27, 8'h22};
      SC_SPACE: {w_lo, w_hi} = {ASC_SPACE, ASC_SPACE};
      SC_ENTER: {w_lo, w_hi} = {ASC_CR, ASC_CR};
      SC_BKSP:  {w_lo, w_hi} = {ASC_BS, ASC_BS};
      SC_TAB:   {w_lo, w_hi} = {ASC_TAB, ASC_TAB};
      SC_ESC:   {w_lo, w_hi} = {ASC_ESC, ASC_ESC};
      default: ;
    endcase
    // letters: caps inverts the shift sense; other glyphs follow shift only
    if (w_alpha) begin
      w_hi = w_lo ^ 8'h20;
      o_ascii = (i_shift ^ i_caps) ? w_hi : w_lo;
    end else begin
      o_ascii = i_shift ? w_hi : w_lo;
    end
  end

endmodule

// File: rtl/keyboard_ascii_fifo.sv
// Key event detect, shift/caps tracking, one-stage translate pipeline
// and a first-word-fall-through character FIFO for the CPU port.
module keyboard_ascii_fifo
  import keyboard_ascii_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] keycode,
  input  logic       is_break,
  input  logic       pop,
  output logic [7:0] ascii,
  output logic       valid,
  output logic       full,
  output logic       overflow,
  output logic       shift_on,
  output logic       caps_on
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LP_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [8:0]            w_ev;
  logic [8:0]            r_prev;
  logic                  w_event;
  logic                  w_mod;
  logic [7:0]            w_rom_ch;
  logic                  r_shl;
  logic                  r_shr;
  logic                  r_caps;
  kb_pipe_t              r_pipe;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wp;
  logic [DEPTH_LOG2-1:0] r_rp;
  logic [DEPTH_LOG2:0]   r_cnt;
  logic                  r_ovf;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_rd;
  logic                  w_wr;

  assign w_ev    = {is_break, keycode};
  assign w_event = (w_ev != r_prev) && (keycode != 8'h00);
  assign w_mod   = is_modifier(keycode);

  assign shift_on = r_shl | r_shr;
  assign caps_on  = r_caps;

  ps2_ascii_rom u_rom (
    .i_code  (keycode),
    .i_shift (shift_on),
    .i_caps  (r_caps),
    .o_ascii (w_rom_ch)
  );

  // reset captures the held driver output so it is not a fresh event
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= w_ev;
      r_shl  <= 1'b0;
      r_shr  <= 1'b0;
      r_caps <= 1'b0;
      r_pipe <= '0;
    end else begin
      r_prev      <= w_ev;
      r_pipe.ch   <= w_rom_ch;
      r_pipe.push <= w_event && !is_break && !w_mod
                     && (w_rom_ch != ASC_NUL);
      if (w_event) begin
        unique case (1'b1)
          (keycode == SC_LSHIFT): r_shl <= !is_break;
          (keycode == SC_RSHIFT): r_shr <= !is_break;
          (keycode == SC_CAPS):   if (!is_break) r_caps <= !r_caps;
          default: ;
        endcase
      end
    end
  end

  assign w_full  = (r_cnt == LP_FULL);
  assign w_empty = (r_cnt == '0);
  assign w_rd    = pop && !w_empty;
  assign w_wr    = r_pipe.push && (!w_full || w_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      if (r_pipe.push && !w_wr) r_ovf <= 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= r_pipe.ch;
  end

  assign ascii    = w_empty ? 8'h00 : r_mem[r_rp];
  assign valid    = !w_empty;
  assign full     = w_full;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_keyboard_ascii_fifo.sv
// Scoreboard bench for keyboard_ascii_fifo: stimulus queues expected
// chars, a negedge monitor pops and compares.
module tb_keyboard_ascii_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] keycode;
  logic       is_break;
  logic       pop = 1'b0;
  logic [7:0] ascii;
  logic       valid;
  logic       full;
  logic       overflow;
  logic       shift_on;
  logic       caps_on;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q [$];
  logic drain = 1'b0;
  logic force_pop = 1'b0;

  logic [7:0] letters [17] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15
  };

  keyboard_ascii_fifo #(.DEPTH_LOG2(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .keycode  (keycode),
    .is_break (is_break),
    .pop      (pop),
    .ascii    (ascii),
    .valid    (valid),
    .full     (full),
    .overflow (overflow),
    .shift_on (shift_on),
    .caps_on  (caps_on)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic key(input logic [7:0] c, input logic b);
    keycode  = c;
    is_break = b;
    cyc(3);
  endtask

  task automatic do_reset();
    drain = 1'b0;
    rst   = 1'b1;
    cyc(2);
    rst   = 1'b0;
    cyc(1);
  endtask

  // monitor: pops the head whenever the consumer side is enabled
  always @(negedge clk) begin
    logic pop_now;
    pop_now = force_pop || (drain && valid);
    if (pop_now && valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_char: got %0h expected none", ascii);
      end else begin
        chk("fifo_order", ascii, exp_q.pop_front());
      end
    end
    pop = pop_now;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset with 'a' make held, no spurious char afterwards
    rst = 1'b1;
    keycode = 8'h1C;
    is_break = 1'b0;
    cyc(3);
    rst = 1'b0;
    chk("rst_valid", valid, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_shift", shift_on, 0);
    chk("rst_caps", caps_on, 0);
    chk("rst_ascii", ascii, 0);
    repeat (20) begin
      @(negedge clk);
      chk("no_spurious", valid, 0);
    end
    cyc(1);

    // 2: exact two-edge latency, break adds nothing
    key(8'h00, 1'b0);
    keycode = 8'h1C;
    cyc(1);
    chk("lat_edgeN", valid, 0);
    cyc(1);
    chk("lat_valid", valid, 1);
    chk("lat_ascii", ascii, 8'h61);
    exp_q.push_back(8'h61);
    drain = 1'b1;
    cyc(3);
    key(8'h1C, 1'b1);
    cyc(2);
    chk("break_nochar", valid, 0);
    chk("q_drained2", exp_q.size(), 0);

    // 3: shift and caps
    key(8'h12, 1'b0);
    chk("shift_on", shift_on, 1);
    exp_q.push_back(8'h41);
    key(8'h1C, 1'b0);
    key(8'h1C, 1'b1);
    exp_q.push_back(8'h21);
    key(8'h16, 1'b0);
    key(8'h16, 1'b1);
    key(8'h12, 1'b1);
    chk("shift_off", shift_on, 0);
    key(8'h58, 1'b0);
    key(8'h58, 1'b1);
    chk("caps_on", caps_on, 1);
    key(8'h12, 1'b0);
    exp_q.push_back(8'h61);
    key(8'h1C, 1'b0);
    chk("caps_still", caps_on, 1);
    chk("shift_again", shift_on, 1);
    key(8'h12, 1'b1);
    key(8'h58, 1'b0);
    key(8'h58, 1'b1);
    chk("caps_off", caps_on, 0);
    cyc(2);
    chk("q_drained3", exp_q.size(), 0);

    // 4: full and overflow
    drain = 1'b0;
    for (int i = 0; i < 17; i++) begin
      key(letters[i], 1'b0);
      if (i == 15) begin
        chk("full_at16", full, 1);
        chk("no_ovf_at16", overflow, 0);
      end
    end
    chk("full_at17", full, 1);
    chk("ovf_at17", overflow, 1);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h61 + 8'(i));
    drain = 1'b1;
    cyc(25);
    chk("empty_after16", valid, 0);
    chk("q_drained4", exp_q.size(), 0);
    chk("ovf_sticky", overflow, 1);

    // 5: push and pop on the same edge while full
    do_reset();
    chk("ovf_cleared", overflow, 0);
    for (int i = 0; i < 16; i++) key(letters[i], 1'b0);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h61 + 8'(i));
    chk("full_again", full, 1);
    exp_q.push_back(8'h72);
    keycode = 8'h2D;
    is_break = 1'b0;
    cyc(1);
    force_pop = 1'b1;
    cyc(1);
    force_pop = 1'b0;
    chk("pp_full", full, 1);
    chk("pp_ovf", overflow, 0);
    chk("pp_head", ascii, 8'h62);
    drain = 1'b1;
    cyc(25);
    chk("pp_empty", valid, 0);
    chk("q_drained5", exp_q.size(), 0);

    // pop while empty
    drain = 1'b0;
    force_pop = 1'b1;
    cyc(4);
    force_pop = 1'b0;
    chk("pe_valid", valid, 0);
    chk("pe_full", full, 0);
    exp_q.push_back(8'h62);
    drain = 1'b1;
    key(8'h32, 1'b0);
    cyc(2);
    chk("pe_drained", exp_q.size(), 0);
    chk("pe_valid2", valid, 0);

    // 6: reset mid-operation
    drain = 1'b0;
    key(8'h12, 1'b0);
    key(8'h58, 1'b0);
    for (int i = 2; i < 7; i++) key(letters[i], 1'b0);
    chk("pre_valid", valid, 1);
    chk("pre_shift", shift_on, 1);
    chk("pre_caps", caps_on, 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("r6_valid", valid, 0);
    chk("r6_shift", shift_on, 0);
    chk("r6_caps", caps_on, 0);
    chk("r6_ovf", overflow, 0);
    chk("r6_ascii", ascii, 0);
    cyc(5);
    chk("r6_quiet", valid, 0);
    chk("q_final", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
